// File: rtl/dll_shift_apply.sv
// dll_shift_apply
//   Consumer end of the DLL discriminator result interface. Per-channel
//   code-phase corrections are accumulated as signed pending shifts and
//   handed to the code generator one channel at a time over a valid/ack
//   slew handshake. Each slew is capped at MAX_SLEW and channels are served
//   round-robin, so a single busy channel cannot starve the others.
//
// Ports
//   clk              system clock
//   global_reset_n   asynchronous reset, active-low (deassertion synchronised)
//   result_ready     one-cycle strobe, DLL result valid
//   result_tag       channel of the result (tags >= NUM_CHANNELS are dropped)
//   shift_direction  1 = negative shift, 0 = positive
//   shift_amount     unsigned shift magnitude
//   slew_valid       slew request valid (held until slew_ack)
//   slew_tag         channel being slewed
//   slew_dir         1 = negative slew
//   slew_amount      slew magnitude, 1..MAX_SLEW
//   slew_ack         code generator accepts the request
//   pending_nonzero  bit i = channel i has a nonzero pending shift
//   sat_event        one-cycle pulse when an accumulator saturates
//
// Optional feature
//   DLL_SHIFT_DEADBAND_EN: when defined, results with shift_amount <= DEADBAND
//   are discarded at capture.
//
// FSM states
//   state | meaning
//   IDLE  | scan pointer walks channels looking for a nonzero pending shift
//   ISSUE | slew request presented, payload frozen until slew_ack

module dll_shift_apply #(
    parameter int NUM_CHANNELS = 4,
    parameter int CHAN_W       = 2,
    parameter int SHIFT_W      = 5,
    parameter int PEND_W       = 8,
    parameter int MAX_SLEW     = 4,
    parameter int DEADBAND     = 1
) (
    input  logic                    clk,
    input  logic                    global_reset_n,
    input  logic                    result_ready,
    input  logic [CHAN_W-1:0]       result_tag,
    input  logic                    shift_direction,
    input  logic [SHIFT_W-1:0]      shift_amount,
    output logic                    slew_valid,
    output logic [CHAN_W-1:0]       slew_tag,
    output logic                    slew_dir,
    output logic [SHIFT_W-1:0]      slew_amount,
    input  logic                    slew_ack,
    output logic [NUM_CHANNELS-1:0] pending_nonzero,
    output logic                    sat_event
);

    // Two guard bits so pend - issued + incoming never wraps before the clamp.
    localparam int SUM_W = PEND_W + 2;
    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(2**(PEND_W-1) - 1);
    localparam logic signed [SUM_W-1:0] SAT_LO = -SAT_HI;
    localparam logic [CHAN_W-1:0]       LAST_CH = CHAN_W'(NUM_CHANNELS - 1);

    if (MAX_SLEW < 1 || MAX_SLEW >= 2**SHIFT_W || 2**CHAN_W < NUM_CHANNELS ||
        DEADBAND < 0 || SUM_W <= SHIFT_W) begin : g_bad_params
        $error("dll_shift_apply: inconsistent parameters");
    end

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                    state, state_next;
    logic [1:0]                rst_sync;
    logic                      rst_n;
    logic [CHAN_W-1:0]         ptr, ptr_next;
    logic signed [PEND_W-1:0]  pend      [NUM_CHANNELS];
    logic signed [PEND_W-1:0]  pend_next [NUM_CHANNELS];
    logic [2**CHAN_W-1:0]      tag_mask;
    logic                      tag_ok;
    logic                      cap_en;
    logic                      load;
    logic                      done;
    logic                      sat_any;
    logic signed [SUM_W-1:0]   in_val;
    logic signed [SUM_W-1:0]   iss_val;
    logic signed [SUM_W-1:0]   sum_tmp;
    logic signed [PEND_W-1:0]  cur;
    logic [PEND_W-1:0]         cur_mag;
    logic [SHIFT_W-1:0]        cur_amt;

    // Reset asserts asynchronously, releases two clocks later.
    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) rst_sync <= 2'b00;
        else                 rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    always_comb begin
        tag_mask = '0;
        for (int i = 0; i < 2**CHAN_W; i++) tag_mask[i] = (i < NUM_CHANNELS);
    end
    assign tag_ok = tag_mask[result_tag];

`ifdef DLL_SHIFT_DEADBAND_EN
    assign cap_en = result_ready && tag_ok && (shift_amount > SHIFT_W'(DEADBAND));
`else
    assign cap_en = result_ready && tag_ok;
`endif

    assign in_val  = shift_direction ? -SUM_W'(shift_amount) : SUM_W'(shift_amount);
    assign iss_val = slew_dir ? -SUM_W'(slew_amount) : SUM_W'(slew_amount);

    // Payload candidate for the channel under the scan pointer.
    assign cur     = pend[ptr];
    assign cur_mag = cur[PEND_W-1] ? PEND_W'(-cur) : PEND_W'(cur);
    assign cur_amt = (cur_mag > PEND_W'(MAX_SLEW)) ? SHIFT_W'(MAX_SLEW) : SHIFT_W'(cur_mag);

    // Incoming result and completed slew fold into one saturating add.
    always_comb begin
        sat_any = 1'b0;
        sum_tmp = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            sum_tmp = SUM_W'(pend[i]);
            if (cap_en && result_tag == CHAN_W'(i)) sum_tmp = sum_tmp + in_val;
            if (done && slew_tag == CHAN_W'(i))     sum_tmp = sum_tmp - iss_val;
            if (sum_tmp > SAT_HI) begin
                pend_next[i] = PEND_W'(SAT_HI);
                sat_any      = 1'b1;
            end else if (sum_tmp < SAT_LO) begin
                pend_next[i] = PEND_W'(SAT_LO);
                sat_any      = 1'b1;
            end else begin
                pend_next[i] = PEND_W'(sum_tmp);
            end
        end
    end

    function automatic logic [CHAN_W-1:0] ptr_inc(input logic [CHAN_W-1:0] p);
        return (p == LAST_CH) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // The registered nonzero flag gates the scan, so a fresh result has one
    // cycle to merge with a back-to-back follow-up before it is issued.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        load       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (pending_nonzero[ptr] && cur != '0) begin
                    load       = 1'b1;
                    state_next = ISSUE;
                end else begin
                    ptr_next = ptr_inc(ptr);
                end
            end
            ISSUE: begin
                if (slew_valid && slew_ack) begin
                    done       = 1'b1;
                    state_next = IDLE;
                    ptr_next   = ptr_inc(slew_tag);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr             <= '0;
            slew_valid      <= 1'b0;
            slew_tag        <= '0;
            slew_dir        <= 1'b0;
            slew_amount     <= '0;
            pending_nonzero <= '0;
            sat_event       <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) pend[i] <= '0;
        end else begin
            ptr       <= ptr_next;
            sat_event <= sat_any;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                pend[i]            <= pend_next[i];
                pending_nonzero[i] <= (pend[i] != '0);
            end
            if (load) begin
                slew_valid  <= 1'b1;
                slew_tag    <= ptr;
                slew_dir    <= cur[PEND_W-1];
                slew_amount <= cur_amt;
            end else if (done) begin
                slew_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dll_shift_apply.sv
module tb_dll_shift_apply;

    logic       clk;
    logic       global_reset_n;
    logic       result_ready;
    logic       result_ready2;
    logic [1:0] result_tag;
    logic       shift_direction;
    logic [4:0] shift_amount;
    logic       slew_ack;
    logic       slew_ack2;

    logic       slew_valid, slew_valid2;
    logic [1:0] slew_tag, slew_tag2;
    logic       slew_dir, slew_dir2;
    logic [4:0] slew_amount, slew_amount2;
    logic [3:0] pending_nonzero;
    logic [2:0] pending_nonzero2;
    logic       sat_event, sat_event2;

    int tests = 0;
    int fails = 0;

    dll_shift_apply dut (
        .clk(clk), .global_reset_n(global_reset_n),
        .result_ready(result_ready), .result_tag(result_tag),
        .shift_direction(shift_direction), .shift_amount(shift_amount),
        .slew_valid(slew_valid), .slew_tag(slew_tag), .slew_dir(slew_dir),
        .slew_amount(slew_amount), .slew_ack(slew_ack),
        .pending_nonzero(pending_nonzero), .sat_event(sat_event)
    );

    // Three channels on a 2-bit tag, so tag 3 is out of range.
    dll_shift_apply #(.NUM_CHANNELS(3)) dut2 (
        .clk(clk), .global_reset_n(global_reset_n),
        .result_ready(result_ready2), .result_tag(result_tag),
        .shift_direction(shift_direction), .shift_amount(shift_amount),
        .slew_valid(slew_valid2), .slew_tag(slew_tag2), .slew_dir(slew_dir2),
        .slew_amount(slew_amount2), .slew_ack(slew_ack2),
        .pending_nonzero(pending_nonzero2), .sat_event(sat_event2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] tag, input logic dir, input logic [4:0] amt);
        result_ready    = 1'b1;
        result_tag      = tag;
        shift_direction = dir;
        shift_amount    = amt;
        @(negedge clk);
        result_ready    = 1'b0;
    endtask

    task automatic wait_slew(input string name, input logic [1:0] tag,
                             input logic dir, input logic [4:0] amt);
        int n = 0;
        while (!slew_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, ".valid"}, slew_valid, 1);
        chk({name, ".tag"},   slew_tag, tag);
        chk({name, ".dir"},   slew_dir, dir);
        chk({name, ".amt"},   slew_amount, amt);
    endtask

    task automatic do_ack(input string name);
        slew_ack = 1'b1;
        @(negedge clk);
        slew_ack = 1'b0;
        chk({name, ".drop"}, slew_valid, 0);
    endtask

    initial begin
        int seen;
        int sat_cnt;
        int n;

        global_reset_n  = 1'b0;
        result_ready    = 1'b0;
        result_ready2   = 1'b0;
        result_tag      = 2'd0;
        shift_direction = 1'b0;
        shift_amount    = 5'd0;
        slew_ack        = 1'b1;
        slew_ack2       = 1'b0;

        // Reset with ack stuck high
        repeat (3) @(negedge clk);
        chk("rst.valid", slew_valid, 0);
        chk("rst.tag",   slew_tag, 0);
        chk("rst.dir",   slew_dir, 0);
        chk("rst.amt",   slew_amount, 0);
        chk("rst.pnz",   pending_nonzero, 0);
        chk("rst.sat",   sat_event, 0);
        global_reset_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (slew_valid) seen++;
        end
        chk("rst.idle_no_valid", seen, 0);
        slew_ack = 1'b0;

        // Single result split over three transfers
        send(2'd2, 1'b0, 5'd10);
        wait_slew("split0", 2'd2, 1'b0, 5'd4);
        do_ack("split0");
        wait_slew("split1", 2'd2, 1'b0, 5'd4);
        do_ack("split1");
        wait_slew("split2", 2'd2, 1'b0, 5'd2);
        // Load ch0/ch1 while the last ch2 slew is held; pointer resumes at 3.
        send(2'd0, 1'b0, 5'd8);
        send(2'd1, 1'b1, 5'd3);
        chk("split2.hold_valid", slew_valid, 1);
        chk("split2.hold_amt",   slew_amount, 2);
        do_ack("split2");
        @(negedge clk);
        chk("split.pnz", pending_nonzero, 4'b0011);

        // Round-robin ordering
        wait_slew("rr0", 2'd0, 1'b0, 5'd4);
        do_ack("rr0");
        wait_slew("rr1", 2'd1, 1'b1, 5'd3);
        do_ack("rr1");
        wait_slew("rr2", 2'd0, 1'b0, 5'd4);
        do_ack("rr2");
        repeat (2) @(negedge clk);
        chk("rr.pnz", pending_nonzero, 4'b0000);

        // Coincident result and ack on ch3: 4 - 4 - 6 = -6
        send(2'd3, 1'b0, 5'd4);
        wait_slew("co0", 2'd3, 1'b0, 5'd4);
        result_ready    = 1'b1;
        result_tag      = 2'd3;
        shift_direction = 1'b1;
        shift_amount    = 5'd6;
        slew_ack        = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        slew_ack     = 1'b0;
        chk("co0.drop", slew_valid, 0);
        wait_slew("co1", 2'd3, 1'b1, 5'd4);
        do_ack("co1");
        wait_slew("co2", 2'd3, 1'b1, 5'd2);
        do_ack("co2");
        repeat (2) @(negedge clk);
        chk("co.pnz", pending_nonzero, 4'b0000);

        // Saturation: 16 x +31 on ch1, ack held low; adds 5..16 clamp
        sat_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            result_ready    = 1'b1;
            result_tag      = 2'd1;
            shift_direction = 1'b0;
            shift_amount    = 5'd31;
            @(negedge clk);
            if (sat_event) sat_cnt++;
        end
        result_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (sat_event) sat_cnt++;
        end
        chk("sat.count", sat_cnt, 12);
        chk("sat.pnz",   pending_nonzero, 4'b0010);
        // +127 drains as 31 x 4 + 3
        for (int i = 0; i < 31; i++) begin
            wait_slew($sformatf("drain%0d", i), 2'd1, 1'b0, 5'd4);
            do_ack($sformatf("drain%0d", i));
        end
        wait_slew("drain_last", 2'd1, 1'b0, 5'd3);
        do_ack("drain_last");
        repeat (2) @(negedge clk);
        chk("drain.pnz", pending_nonzero, 4'b0000);

        // Dropped tag on the 3-channel instance, then a legal one
        result_ready2   = 1'b1;
        result_tag      = 2'd3;
        shift_direction = 1'b0;
        shift_amount    = 5'd5;
        @(negedge clk);
        result_ready2 = 1'b0;
        repeat (6) @(negedge clk);
        chk("drop.valid", slew_valid2, 0);
        chk("drop.pnz",   pending_nonzero2, 3'b000);
        chk("drop.sat",   sat_event2, 0);
        result_ready2 = 1'b1;
        result_tag    = 2'd2;
        @(negedge clk);
        result_ready2 = 1'b0;
        n = 0;
        while (!slew_valid2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drop2.valid", slew_valid2, 1);
        chk("drop2.tag",   slew_tag2, 2);
        chk("drop2.amt",   slew_amount2, 4);
        slew_ack2 = 1'b1;
        @(negedge clk);
        slew_ack2 = 1'b0;
        n = 0;
        while (!slew_valid2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drop3.amt", slew_amount2, 1);
        slew_ack2 = 1'b1;
        @(negedge clk);
        slew_ack2 = 1'b0;
        chk("drop3.drop", slew_valid2, 0);

        // Deadband: amounts 1 then 2 on ch0
        send(2'd0, 1'b0, 5'd1);
        send(2'd0, 1'b0, 5'd2);
`ifdef DLL_SHIFT_DEADBAND_EN
        wait_slew("db", 2'd0, 1'b0, 5'd2);
`else
        wait_slew("db", 2'd0, 1'b0, 5'd3);
`endif
        do_ack("db");
        repeat (2) @(negedge clk);
        chk("db.pnz", pending_nonzero, 4'b0000);

        // Reset mid-transfer drops the request with no ack
        send(2'd0, 1'b0, 5'd5);
        wait_slew("mid", 2'd0, 1'b0, 5'd4);
        #2 global_reset_n = 1'b0;
        #1;
        chk("mid.valid", slew_valid, 0);
        chk("mid.pnz",   pending_nonzero, 4'b0000);
        @(negedge clk);
        global_reset_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (slew_valid) seen++;
        end
        chk("mid.no_residual", seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
